// File: rtl/core_dispatch_pkg.sv
// Shared types and constants for the core instruction dispatcher.
// Holds the FSM state type, the instruction class encodings and the default unit class map.
package core_dispatch_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXEC   = 2'd1,
    RETIRE = 2'd2
  } dispatch_state_e;

  localparam logic [2:0] CLASS_ALU  = 3'b100;
  localparam logic [2:0] CLASS_PFCU = 3'b110;
  localparam logic [2:0] CLASS_MIOU = 3'b010;

  // Slice k is unit k's class: unit0=ALU, unit1=PFCU, unit2=MIOU.
  localparam logic [8:0] DEFAULT_UNIT_CLASSES = {CLASS_MIOU, CLASS_PFCU, CLASS_ALU};

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dispatch_class_decoder.sv
// Combinational priority match of an instruction class against the per-unit class map.
// When several units share a class, the lowest unit index wins.
module dispatch_class_decoder
  import core_dispatch_pkg::*;
#(
  parameter int unsigned                    NUM_UNITS    = 3,
  parameter int unsigned                    CLASS_W      = 3,
  parameter logic [NUM_UNITS*CLASS_W-1:0]   UNIT_CLASSES = DEFAULT_UNIT_CLASSES,
  parameter int unsigned                    IDX_W        = idx_width(NUM_UNITS)
) (
  input  logic [CLASS_W-1:0] i_inst_class,
  output logic               o_hit,
  output logic [IDX_W-1:0]   o_idx
);

  // Scan from the top down so the lowest matching index is the last one written.
  always_comb begin
    o_hit = 1'b0;
    o_idx = '0;
    for (int k = int'(NUM_UNITS) - 1; k >= 0; k--) begin
      if (i_inst_class == UNIT_CLASSES[k*CLASS_W +: CLASS_W]) begin
        o_hit = 1'b1;
        o_idx = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/core_dispatch_unit.sv
// Instruction dispatcher: enables one execution unit per instruction, forwards its GPR writes
// and retires it. Define DISPATCH_TIMEOUT_EN to add a watchdog that force-retires a hung unit.
module core_dispatch_unit
  import core_dispatch_pkg::*;
#(
  parameter int unsigned                  NUM_UNITS      = 3,
  parameter int unsigned                  NUM_GPRS       = 16,
  parameter int unsigned                  DATA_W         = 32,
  parameter int unsigned                  CLASS_W        = 3,
  parameter logic [NUM_UNITS*CLASS_W-1:0] UNIT_CLASSES   = DEFAULT_UNIT_CLASSES,
  parameter int unsigned                  TIMEOUT_CYCLES = 1024
) (
  input  logic                                i_clk,
  input  logic                                i_rst_n,
  input  logic                                i_inst_pres,
  input  logic [CLASS_W-1:0]                  i_inst_class,
  output logic                                o_rq_nxt_inst,
  output logic [NUM_UNITS-1:0]                o_unit_en,
  input  logic [NUM_UNITS-1:0]                i_unit_done,
  input  logic [NUM_UNITS*NUM_GPRS-1:0]       i_unit_gpr_we,
  input  logic [NUM_UNITS*NUM_GPRS*DATA_W-1:0] i_unit_gpr_wdata,
  output logic [NUM_GPRS-1:0]                 o_gpr_we,
  output logic [NUM_GPRS*DATA_W-1:0]          o_gpr_wdata,
  output logic                                o_illegal_inst,
  output logic                                o_busy,
  output logic [31:0]                         o_retired_cnt
);

  localparam int unsigned IDX_W = idx_width(NUM_UNITS);

  dispatch_state_e       r_state, w_state_d;
  logic [IDX_W-1:0]      r_active_idx, w_active_idx_d;
  logic [NUM_UNITS-1:0]  r_unit_en, w_unit_en_d;
  logic                  r_rq_nxt_inst, w_rq_nxt_inst_d;
  logic                  r_illegal_inst, w_illegal_inst_d;
  logic [31:0]           r_retired_cnt, w_retired_cnt_d;

  logic                  w_dec_hit;
  logic [IDX_W-1:0]      w_dec_idx;
  logic                  w_done_act;
  logic [NUM_GPRS-1:0]   w_gpr_we;
  logic [NUM_GPRS*DATA_W-1:0] w_gpr_wdata;

`ifdef DISPATCH_TIMEOUT_EN
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);
  logic [31:0]           r_to_cnt, w_to_cnt_d;
`else
  logic                  w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT_CYCLES;
`endif

  dispatch_class_decoder #(
    .NUM_UNITS    (NUM_UNITS),
    .CLASS_W      (CLASS_W),
    .UNIT_CLASSES (UNIT_CLASSES),
    .IDX_W        (IDX_W)
  ) u_class_decoder (
    .i_inst_class (i_inst_class),
    .o_hit        (w_dec_hit),
    .o_idx        (w_dec_idx)
  );

  assign w_done_act = i_unit_done[r_active_idx];

  always_comb begin
    w_state_d        = r_state;
    w_active_idx_d   = r_active_idx;
    w_unit_en_d      = r_unit_en;
    w_rq_nxt_inst_d  = 1'b0;
    w_illegal_inst_d = 1'b0;
    w_retired_cnt_d  = r_retired_cnt;
`ifdef DISPATCH_TIMEOUT_EN
    w_to_cnt_d       = r_to_cnt;
`endif
    unique case (r_state)
      IDLE: begin
        // While the retire pulse is out the decoder still shows the old instruction.
        if (i_inst_pres && !r_rq_nxt_inst) begin
          if (w_dec_hit) begin
            w_state_d      = EXEC;
            w_active_idx_d = w_dec_idx;
            w_unit_en_d    = NUM_UNITS'(1) << w_dec_idx;
`ifdef DISPATCH_TIMEOUT_EN
            w_to_cnt_d     = '0;
`endif
          end else begin
            w_rq_nxt_inst_d  = 1'b1;
            w_illegal_inst_d = 1'b1;
            w_retired_cnt_d  = r_retired_cnt + 32'd1;
          end
        end
      end
      EXEC: begin
        if (w_done_act) begin
          w_state_d       = RETIRE;
          w_unit_en_d     = '0;
          w_rq_nxt_inst_d = 1'b1;
          w_retired_cnt_d = r_retired_cnt + 32'd1;
`ifdef DISPATCH_TIMEOUT_EN
        end else if (r_to_cnt == TO_LAST) begin
          w_state_d        = RETIRE;
          w_unit_en_d      = '0;
          w_rq_nxt_inst_d  = 1'b1;
          w_illegal_inst_d = 1'b1;
          w_retired_cnt_d  = r_retired_cnt + 32'd1;
        end else begin
          w_to_cnt_d = r_to_cnt + 32'd1;
`endif
        end
      end
      RETIRE: begin
        w_state_d = IDLE;
      end
      default: begin
        w_state_d   = IDLE;
        w_unit_en_d = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state        <= IDLE;
      r_active_idx   <= '0;
      r_unit_en      <= '0;
      r_rq_nxt_inst  <= 1'b0;
      r_illegal_inst <= 1'b0;
      r_retired_cnt  <= '0;
`ifdef DISPATCH_TIMEOUT_EN
      r_to_cnt       <= '0;
`endif
    end else begin
      r_state        <= w_state_d;
      r_active_idx   <= w_active_idx_d;
      r_unit_en      <= w_unit_en_d;
      r_rq_nxt_inst  <= w_rq_nxt_inst_d;
      r_illegal_inst <= w_illegal_inst_d;
      r_retired_cnt  <= w_retired_cnt_d;
`ifdef DISPATCH_TIMEOUT_EN
      r_to_cnt       <= w_to_cnt_d;
`endif
    end
  end

  // Only the active unit's write bus reaches the register file, and only during EXEC.
  always_comb begin
    w_gpr_we    = '0;
    w_gpr_wdata = '0;
    if (r_state == EXEC) begin
      for (int k = 0; k < int'(NUM_UNITS); k++) begin
        if (r_active_idx == IDX_W'(k)) begin
          w_gpr_we    = i_unit_gpr_we[k*NUM_GPRS +: NUM_GPRS];
          w_gpr_wdata = i_unit_gpr_wdata[k*NUM_GPRS*DATA_W +: NUM_GPRS*DATA_W];
        end
      end
    end
  end

  assign o_unit_en      = r_unit_en;
  assign o_rq_nxt_inst  = r_rq_nxt_inst;
  assign o_illegal_inst = r_illegal_inst;
  assign o_retired_cnt  = r_retired_cnt;
  assign o_busy         = (r_state == EXEC) || (r_state == RETIRE);
  assign o_gpr_we       = w_gpr_we;
  assign o_gpr_wdata    = w_gpr_wdata;

endmodule

// File: tb/tb_core_dispatch_unit.sv
// Directed self-checking bench for core_dispatch_unit (default unit map, TIMEOUT_CYCLES=8).
module tb_core_dispatch_unit;

  localparam int unsigned NU = 3;
  localparam int unsigned NG = 16;
  localparam int unsigned DW = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              inst_pres;
  logic [2:0]        inst_class;
  logic              rq_nxt_inst;
  logic [NU-1:0]     unit_en;
  logic [NU-1:0]     unit_done;
  logic [NU*NG-1:0]  unit_gpr_we;
  logic [NU*NG*DW-1:0] unit_gpr_wdata;
  logic [NG-1:0]     gpr_we;
  logic [NG*DW-1:0]  gpr_wdata;
  logic              illegal_inst;
  logic              busy;
  logic [31:0]       retired_cnt;

  int n_pass  = 0;
  int n_total = 0;

  core_dispatch_unit #(
    .NUM_UNITS      (NU),
    .NUM_GPRS       (NG),
    .DATA_W         (DW),
    .CLASS_W        (3),
    .UNIT_CLASSES   ({3'b010, 3'b110, 3'b100}),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_inst_pres      (inst_pres),
    .i_inst_class     (inst_class),
    .o_rq_nxt_inst    (rq_nxt_inst),
    .o_unit_en        (unit_en),
    .i_unit_done      (unit_done),
    .i_unit_gpr_we    (unit_gpr_we),
    .i_unit_gpr_wdata (unit_gpr_wdata),
    .o_gpr_we         (gpr_we),
    .o_gpr_wdata      (gpr_wdata),
    .o_illegal_inst   (illegal_inst),
    .o_busy           (busy),
    .o_retired_cnt    (retired_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Outputs are sampled 1 time unit after the active edge; inputs change at the same point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n          = 1'b0;
    inst_pres      = 1'b1;
    inst_class     = 3'b100;
    unit_done      = '0;
    unit_gpr_we    = '0;
    unit_gpr_wdata = '0;

    // Reset held for 3 cycles with an instruction present.
    repeat (3) begin
      tick();
      chk("rst_unit_en", 64'(unit_en), 64'h0);
      chk("rst_rq", 64'(rq_nxt_inst), 64'h0);
      chk("rst_illegal", 64'(illegal_inst), 64'h0);
      chk("rst_busy", 64'(busy), 64'h0);
      chk("rst_cnt", 64'(retired_cnt), 64'h0);
    end
    rst_n = 1'b1;

    // ALU op: enabled 4 cycles, class change during EXEC ignored.
    tick();
    chk("alu_en_c1", 64'(unit_en), 64'h1);
    chk("alu_busy", 64'(busy), 64'h1);
    inst_pres  = 1'b0;
    inst_class = 3'b111;
    tick();
    chk("alu_en_c2", 64'(unit_en), 64'h1);
    chk("alu_no_ill", 64'(illegal_inst), 64'h0);
    tick();
    chk("alu_en_c3", 64'(unit_en), 64'h1);
    tick();
    chk("alu_en_c4", 64'(unit_en), 64'h1);
    chk("alu_rq_c4", 64'(rq_nxt_inst), 64'h0);
    unit_done = 3'b001;
    tick();
    unit_done = '0;
    chk("alu_ret_en", 64'(unit_en), 64'h0);
    chk("alu_ret_rq", 64'(rq_nxt_inst), 64'h1);
    chk("alu_ret_ill", 64'(illegal_inst), 64'h0);
    chk("alu_ret_cnt", 64'(retired_cnt), 64'd1);
    tick();
    chk("alu_rq_pulse", 64'(rq_nxt_inst), 64'h0);
    chk("alu_idle_busy", 64'(busy), 64'h0);

    // GPR isolation: MIOU active, ALU drives all enables.
    unit_gpr_wdata = {48{32'h11111111}};
    unit_gpr_wdata[2*NG*DW +: NG*DW] = '0;
    unit_gpr_wdata[(2*NG+3)*DW +: DW] = 32'hDEADBEEF;
    unit_gpr_we[0 +: NG]    = 16'hFFFF;
    unit_gpr_we[2*NG +: NG] = 16'h0008;
    inst_pres  = 1'b1;
    inst_class = 3'b010;
    #1;
    chk("idle_gpr_we", 64'(gpr_we), 64'h0);
    tick();
    inst_pres = 1'b0;
    chk("miou_en", 64'(unit_en), 64'h4);
    chk("miou_gpr_we", 64'(gpr_we), 64'h0008);
    chk("miou_r3", 64'(gpr_wdata[3*DW +: DW]), 64'hDEADBEEF);
    chk("miou_r0", 64'(gpr_wdata[0 +: DW]), 64'h0);
    unit_done = 3'b011;
    tick();
    chk("miou_stray_en", 64'(unit_en), 64'h4);
    chk("miou_stray_rq", 64'(rq_nxt_inst), 64'h0);
    unit_done = 3'b100;
    tick();
    unit_done = '0;
    chk("miou_ret_rq", 64'(rq_nxt_inst), 64'h1);
    chk("miou_ret_cnt", 64'(retired_cnt), 64'd2);
    chk("miou_ret_gpr_we", 64'(gpr_we), 64'h0);
    tick();
    unit_gpr_we = '0;

    // Illegal class: decoder keeps showing it during the pulse, must not re-accept.
    inst_pres  = 1'b1;
    inst_class = 3'b111;
    tick();
    chk("ill_pulse", 64'(illegal_inst), 64'h1);
    chk("ill_rq", 64'(rq_nxt_inst), 64'h1);
    chk("ill_en", 64'(unit_en), 64'h0);
    chk("ill_busy", 64'(busy), 64'h0);
    chk("ill_cnt", 64'(retired_cnt), 64'd3);
    tick();
    chk("ill_pulse_end", 64'(illegal_inst), 64'h0);
    chk("ill_rq_end", 64'(rq_nxt_inst), 64'h0);
    chk("ill_cnt_once", 64'(retired_cnt), 64'd3);

    // PFCU with stray done from ALU.
    inst_class = 3'b110;
    tick();
    inst_pres = 1'b0;
    chk("pfcu_en", 64'(unit_en), 64'h2);
    unit_done = 3'b101;
    tick();
    chk("pfcu_stray_en", 64'(unit_en), 64'h2);
    chk("pfcu_stray_rq", 64'(rq_nxt_inst), 64'h0);
    unit_done = 3'b010;
    tick();
    unit_done = '0;
    chk("pfcu_ret_rq", 64'(rq_nxt_inst), 64'h1);
    chk("pfcu_ret_cnt", 64'(retired_cnt), 64'd4);
    chk("pfcu_ret_en", 64'(unit_en), 64'h0);
    tick();

    // Minimum latency, back-to-back: accept c0, enable c1, retire c2, next accept c3.
    inst_pres  = 1'b1;
    inst_class = 3'b100;
    unit_done  = 3'b001;
    tick();
    chk("min_en_c1", 64'(unit_en), 64'h1);
    tick();
    chk("min_rq_c2", 64'(rq_nxt_inst), 64'h1);
    chk("min_cnt_c2", 64'(retired_cnt), 64'd5);
    tick();
    chk("min_idle_c3", 64'(busy), 64'h0);
    chk("min_rq_c3", 64'(rq_nxt_inst), 64'h0);
    tick();
    chk("b2b_en", 64'(unit_en), 64'h1);
    tick();
    chk("b2b_rq", 64'(rq_nxt_inst), 64'h1);
    chk("b2b_cnt", 64'(retired_cnt), 64'd6);

    // Reset in the middle of EXEC.
    inst_class = 3'b110;
    unit_done  = '0;
    tick();
    tick();
    chk("mid_en", 64'(unit_en), 64'h2);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_en", 64'(unit_en), 64'h0);
    chk("mid_rst_busy", 64'(busy), 64'h0);
    chk("mid_rst_cnt", 64'(retired_cnt), 64'h0);
    inst_pres = 1'b0;
    #1 rst_n = 1'b1;
    tick();
    chk("post_rst_en", 64'(unit_en), 64'h0);
    chk("post_rst_cnt", 64'(retired_cnt), 64'h0);

    // Hung unit: MIOU never signals done for 8 enabled cycles.
    inst_pres  = 1'b1;
    inst_class = 3'b010;
    tick();
    inst_pres = 1'b0;
    chk("hang_en_c1", 64'(unit_en), 64'h4);
    for (int i = 2; i <= 8; i++) begin
      tick();
      chk("hang_en", 64'(unit_en), 64'h4);
    end
`ifdef DISPATCH_TIMEOUT_EN
    tick();
    chk("to_en", 64'(unit_en), 64'h0);
    chk("to_rq", 64'(rq_nxt_inst), 64'h1);
    chk("to_ill", 64'(illegal_inst), 64'h1);
    chk("to_cnt", 64'(retired_cnt), 64'd1);
    tick();
    chk("to_idle_busy", 64'(busy), 64'h0);
    chk("to_rq_end", 64'(rq_nxt_inst), 64'h0);
    chk("to_ill_end", 64'(illegal_inst), 64'h0);
`else
    repeat (4) tick();
    chk("wait_en", 64'(unit_en), 64'h4);
    chk("wait_rq", 64'(rq_nxt_inst), 64'h0);
    unit_done = 3'b100;
    tick();
    unit_done = '0;
    chk("wait_ret_rq", 64'(rq_nxt_inst), 64'h1);
    chk("wait_ret_ill", 64'(illegal_inst), 64'h0);
    chk("wait_ret_cnt", 64'(retired_cnt), 64'd1);
    tick();
    chk("wait_idle_busy", 64'(busy), 64'h0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/core_dispatch_unit.md
Name: core_dispatch_unit

Overview:
- Parametrised instruction dispatcher between the instruction decoder/queue and N execution units (ALU, PFCU, MIOU, future units).
- Matches the current instruction's class field against a per-unit class map and raises a registered enable to exactly one unit.
- Waits for that unit's done, muxes only that unit's GPR write bus to the register file, then pulses the next-instruction request.
- Replaces the ad-hoc combinational dispatch inside core with an FSM that has illegal-class handling and a performance counter.

Parameters:
- NUM_UNITS, 3, number of execution units attached.
- NUM_GPRS, 16, number of general purpose registers.
- DATA_W, 32, GPR width.
- CLASS_W, 3, width of the instruction class field (inst[CLASS_W-1:0]).
- UNIT_CLASSES, {3'b010,3'b110,3'b100}, packed NUM_UNITS*CLASS_W map; slice k is unit k's class, so unit0=ALU, unit1=PFCU, unit2=MIOU.
- TIMEOUT_CYCLES, 1024, watchdog limit; used only with DISPATCH_TIMEOUT_EN.

Ports:
- clk  in  1  core clock.
- rst  in  1  reset; asynchronous, active-low (0 = reset).
- inst_pres  in  1  decoder holds a valid current instruction.
- inst_class  in  CLASS_W  class field of the current instruction.
- rq_nxt_inst  out  1  one-cycle pulse: current instruction retired, advance queue.
- unit_en  out  NUM_UNITS  one-hot enable to execution units.
- unit_done  in  NUM_UNITS  per-unit completion.
- unit_gpr_we  in  NUM_UNITS*NUM_GPRS  per-unit GPR write enables.
- unit_gpr_wdata  in  NUM_UNITS*NUM_GPRS*DATA_W  per-unit GPR write data.
- gpr_we  out  NUM_GPRS  write enables to the register file.
- gpr_wdata  out  NUM_GPRS*DATA_W  write data to the register file.
- illegal_inst  out  1  one-cycle pulse on an unmapped class.
- busy  out  1  high while in EXEC or RETIRE.
- retired_cnt  out  32  count of retired instructions, legal and illegal.

Behaviour:
Reset:
- While rst=0, asynchronously: state=IDLE, unit_en=0, rq_nxt_inst=0, illegal_inst=0, busy=0, retired_cnt=0.
- gpr_we=0 in every state other than EXEC.

FSM states IDLE, EXEC, RETIRE:
- IDLE:
  - inst_pres=1 and class matches unit k: latch k into active_idx, go to EXEC. unit_en[k]=1 from the next cycle (registered).
  - inst_pres=1 and no match: illegal_inst=1 and rq_nxt_inst=1 next cycle, retired_cnt+1, stay IDLE. No unit is enabled and no GPR is written.
  - inst_pres=0: hold.
- EXEC:
  - unit_en[active_idx]=1.
  - gpr_we/gpr_wdata = slices of unit active_idx; all other units' buses are ignored.
  - Sampling unit_done[active_idx]=1 goes to RETIRE, drops unit_en, and blocks GPR writes after that cycle.
  - done from any other unit is ignored.
- RETIRE: rq_nxt_inst=1 for exactly one cycle, retired_cnt+1 (wraps at 2^32-1 to 0), go to IDLE.
- Min latency: accept at cycle 0, enable at cycle 1, done at cycle 1, rq_nxt_inst at cycle 2. The next accept is possible at cycle 3.
- Duplicate class entries in UNIT_CLASSES: lowest index wins.
- inst_class changing during EXEC is ignored; the class is latched at accept.
- Reset asserted mid-EXEC: unit_en drops immediately, the in-flight instruction is abandoned and not counted.

Optional Feature:
- Macro DISPATCH_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in EXEC.
  - If done has not arrived after TIMEOUT_CYCLES enabled cycles: drop unit_en, assert illegal_inst together with the RETIRE pulse, retire normally, count it.
  - Counter clears on every accept.
- Undefined: no counter; EXEC waits indefinitely for done.

Decomposition:
- Package core_dispatch_pkg holds:
  - dispatch_state_e (IDLE, EXEC, RETIRE).
  - Class constants CLASS_ALU=3'b100, CLASS_PFCU=3'b110, CLASS_MIOU=3'b010.
  - Default UNIT_CLASSES value.
- One sub-module, dispatch_class_decoder: combinational priority match of inst_class against UNIT_CLASSES; outputs hit and idx.

Test Plan:
- Reset: rst=0 for 3 cycles with inst_pres=1 -> all outputs 0 and unit_en=000 throughout; after release, dispatch starts within 1 cycle.
- ALU op: class 3'b100, unit_done[0] raised 4 cycles after unit_en -> unit_en=001 for 4 cycles, rq_nxt_inst single pulse, retired_cnt=1.
- GPR isolation: MIOU active, unit2 drives we=16'h0008 data 32'hDEADBEEF on r3, unit0 drives we=16'hFFFF -> gpr_we=16'h0008, r3 data=32'hDEADBEEF.
- Illegal class: class 3'b111 -> illegal_inst and rq_nxt_inst pulse together one cycle after accept, unit_en stays 0, retired_cnt+1.
- Stray done: PFCU active, unit_done[0] pulses -> no retire; retire only on unit_done[1].
- With DISPATCH_TIMEOUT_EN and TIMEOUT_CYCLES=8: unit never signals done -> unit_en drops after 8 cycles, illegal_inst and rq_nxt_inst pulse, FSM returns to IDLE.
